// File: rtl/act_pkg.sv
// Shared definitions for the activation write-back stage: state encoding,
// default geometry and the per-lane ReLU-derivative helpers.
package act_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_PACTIVATION = 128;

    // Widest lane the mask helper can examine; lanes are zero-extended into it.
    localparam int LANE_MAX_WIDTH  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } act_state_t;

    // Bit offset of the least significant bit of lane 'lane' in a packed vector.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

    // dReLU of one lane: positive and not zero. Both +0 and -0 give 0.
    function automatic logic reluMask(input logic [LANE_MAX_WIDTH-1:0] lane,
                                      input int width);
        logic [LANE_MAX_WIDTH-1:0] sign_bit;
        logic [LANE_MAX_WIDTH-1:0] mag_bits;
        sign_bit = 64'd1 << (width - 1);
        mag_bits = sign_bit - 64'd1;
        return ((lane & sign_bit) == 64'd0) && ((lane & mag_bits) != 64'd0);
    endfunction

endpackage

// File: rtl/act_wb_fifo.sv
// Small synchronous FIFO that decouples the ReLU datapath from the buffer port.
// Registered storage with a combinational read of the head entry; an entry
// pushed into an empty FIFO is visible on dout only in the following cycle.
module act_wb_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [width-1:0] dout
);

    localparam int ptrWidth = (depth > 1) ? $clog2(depth) : 1;

    logic [width-1:0]  mem [depth];
    logic [ptrWidth-1:0] wr_ptr;
    logic [ptrWidth-1:0] rd_ptr;
    logic [ptrWidth:0]   count;
    logic                do_push;
    logic                do_pop;

    assign full    = (count == (ptrWidth + 1)'(depth));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array is written without reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap because depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ptrWidth'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ptrWidth'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (ptrWidth + 1)'(1);
                2'b01:   count <= count - (ptrWidth + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/act_writeback.sv
// Activation write-back stage: accepts post-ReLU vectors, tags each lane with
// its dReLU bit and writes them to consecutive buffer addresses, one pass per
// start command.
module act_writeback
    import act_pkg::*;
#(
    parameter int dataWidth   = DEF_DATA_WIDTH,
    parameter int pactivation = DEF_PACTIVATION,
    parameter int addrWidth   = 10,
    parameter int fifoDepth   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [addrWidth-1:0]             baseAddr,
    input  logic [addrWidth-1:0]             numRows,
    input  logic                             inValid,
    output logic                             inReady,
    input  logic [dataWidth*pactivation-1:0] inData,
    output logic                             memWrEn,
    input  logic                             memReady,
    output logic [addrWidth-1:0]             memAddr,
    output logic [dataWidth*pactivation-1:0] memWrData,
    output logic [pactivation-1:0]           memWrMask,
    output logic [addrWidth-1:0]             rowCount,
    output logic                             busy,
    output logic                             done
);

    localparam int vecWidth   = dataWidth * pactivation;
    localparam int entryWidth = vecWidth + pactivation;

    act_state_t           state;
    act_state_t           state_next;
    logic [addrWidth-1:0] base_addr;
    logic [addrWidth-1:0] num_rows;
    logic [addrWidth-1:0] accept_cnt;
    logic [addrWidth-1:0] row_next;
    logic [pactivation-1:0] lane_mask;
    logic                 start_go;
    logic                 push;
    logic                 pop;
    logic                 write_done;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [entryWidth-1:0] fifo_dout;

    assign start_go   = (state == IDLE) && start;
    assign inReady    = (state == RUN) && !fifo_full && (accept_cnt < num_rows);
    assign push       = inValid && inReady;
    assign write_done = memWrEn && memReady;
    assign row_next   = rowCount + addrWidth'(1);
    assign pop        = (state == RUN) && !fifo_empty && (!memWrEn || memReady);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);

    // Derive the dReLU bit of every lane of the incoming vector.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < pactivation; i++) begin
            lane_mask[i] = reluMask(LANE_MAX_WIDTH'(inData[lane_lo(i, dataWidth) +: dataWidth]),
                                    dataWidth);
        end
    end

    act_wb_fifo #(
        .width (entryWidth),
        .depth (fifoDepth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_go),
        .push  (push),
        .pop   (pop),
        .din   ({inData, lane_mask}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    // Pass sequencing: an empty pass skips RUN, and RUN ends on the last completed write.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (numRows == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (write_done && (row_next == num_rows)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pass parameters and the accepted/written vector counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_addr  <= '0;
            num_rows   <= '0;
            accept_cnt <= '0;
            rowCount   <= '0;
        end else if (start_go) begin
            base_addr  <= baseAddr;
            num_rows   <= numRows;
            accept_cnt <= '0;
            rowCount   <= '0;
        end else begin
            if (push) begin
                accept_cnt <= accept_cnt + addrWidth'(1);
            end
            if (write_done) begin
                rowCount <= row_next;
            end
        end
    end

    // Output register: holds while stalled, reloads from the FIFO head as soon
    // as the current write completes so back-to-back writes need no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            memWrEn   <= 1'b0;
            memAddr   <= '0;
            memWrData <= '0;
            memWrMask <= '0;
        end else if (start_go) begin
            memWrEn <= 1'b0;
        end else if (pop) begin
            memWrEn   <= 1'b1;
            memWrData <= fifo_dout[entryWidth-1:pactivation];
            memWrMask <= fifo_dout[pactivation-1:0];
            memAddr   <= base_addr + (write_done ? row_next : rowCount);
        end else if (write_done) begin
            memWrEn <= 1'b0;
        end
    end

endmodule

// File: tb/tb_act_writeback.sv
// Scenario bench for act_writeback: a monitor keeps a scoreboard of accepted
// vectors and checks each completed write against it, while the scenario
// tasks drive passes and check the pass-level behaviour.
module tb_act_writeback;

    localparam int DW = 32;
    localparam int PA = 4;
    localparam int AW = 10;
    localparam int FD = 4;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [DW*PA-1:0] data;
        logic [PA-1:0]    mask;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW-1:0]    baseAddr;
    logic [AW-1:0]    numRows;
    logic             inValid;
    logic             inReady;
    logic [DW*PA-1:0] inData;
    logic             memWrEn;
    logic             memReady;
    logic [AW-1:0]    memAddr;
    logic [DW*PA-1:0] memWrData;
    logic [PA-1:0]    memWrMask;
    logic [AW-1:0]    rowCount;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    exp_t          sb[$];
    logic [AW-1:0] addr_log[$];
    logic [AW-1:0] exp_base;
    int            acc_idx;
    int            writes;
    int            done_cnt;
    int            cyc;
    int            first_wr_cyc;
    int            last_wr_cyc;
    logic [PA-1:0] last_mask;

    logic             prev_stall;
    logic [AW-1:0]    prev_addr;
    logic [DW*PA-1:0] prev_data;
    logic [PA-1:0]    prev_mask;

    act_writeback #(
        .dataWidth   (DW),
        .pactivation (PA),
        .addrWidth   (AW),
        .fifoDepth   (FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .baseAddr  (baseAddr),
        .numRows   (numRows),
        .inValid   (inValid),
        .inReady   (inReady),
        .inData    (inData),
        .memWrEn   (memWrEn),
        .memReady  (memReady),
        .memAddr   (memAddr),
        .memWrData (memWrData),
        .memWrMask (memWrMask),
        .rowCount  (rowCount),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Independent dReLU model: sign clear and magnitude non-zero.
    function automatic logic [PA-1:0] model_mask(input logic [DW*PA-1:0] v);
        logic [PA-1:0] m;
        logic [DW-1:0] lane;
        m = '0;
        for (int i = 0; i < PA; i++) begin
            lane = v[i*DW +: DW];
            m[i] = (lane[DW-1] == 1'b0) && (lane[DW-2:0] != '0);
        end
        return m;
    endfunction

    function automatic logic [DW*PA-1:0] rand_vec();
        logic [DW*PA-1:0] v;
        logic [DW-1:0]    l;
        for (int i = 0; i < PA; i++) begin
            l = $urandom;
            case ($urandom_range(0, 4))
                0: l = 32'h0000_0000;
                1: l = 32'h8000_0000;
                default: ;
            endcase
            v[i*DW +: DW] = l;
        end
        return v;
    endfunction

    // Monitor: scoreboard push on accept, pop and compare on completed write,
    // hold check while stalled, and done pulse counting.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!memWrEn || memAddr !== prev_addr || memWrData !== prev_data ||
                    memWrMask !== prev_mask) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: en=%b addr=%h mask=%b, required en=1 addr=%h mask=%b",
                             memWrEn, memAddr, memWrMask, prev_addr, prev_mask);
                end
            end
            if (inValid && inReady) begin
                e.addr = exp_base + AW'(acc_idx);
                e.data = inData;
                e.mask = model_mask(inData);
                sb.push_back(e);
                acc_idx++;
            end
            if (memWrEn && memReady) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_write: addr=%h, required no write", memAddr);
                end else begin
                    e = sb.pop_front();
                    if (memAddr !== e.addr || memWrData !== e.data || memWrMask !== e.mask) begin
                        errors++;
                        $display("[TB] FAIL write_data: addr=%h data=%h mask=%b, required addr=%h data=%h mask=%b",
                                 memAddr, memWrData, memWrMask, e.addr, e.data, e.mask);
                    end
                end
                if (writes == 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                last_mask   = memWrMask;
                addr_log.push_back(memAddr);
                writes++;
            end
            if (done) done_cnt++;
            prev_stall <= memWrEn && !memReady;
            prev_addr  <= memAddr;
            prev_data  <= memWrData;
            prev_mask  <= memWrMask;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] base, input logic [AW-1:0] n);
        sb.delete();
        addr_log.delete();
        acc_idx  = 0;
        writes   = 0;
        exp_base = base;
        start    = 1'b1;
        baseAddr = base;
        numRows  = n;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int limit, input bit randomize_data);
        int n;
        int d0;
        n  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < limit) begin
            step();
            if (randomize_data) inData = rand_vec();
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("[TB] FAIL done_timeout: no done within %0d cycles, required a done pulse", limit);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; baseAddr = '0; numRows = '0;
        inValid = 1'b0; inData = '0; memReady = 1'b0;
        step(); step();
        checks++;
        if ({inReady, memWrEn, busy, done} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: ready/en/busy/done=%b, required 0000",
                     {inReady, memWrEn, busy, done});
        end
        checks++;
        if (memAddr !== '0 || rowCount !== '0) begin
            errors++;
            $display("[TB] FAIL reset_counts: addr=%h rowCount=%h, required 0 0", memAddr, rowCount);
        end
        checks++;
        if (memWrData !== '0 || memWrMask !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: data=%h mask=%b, required 0", memWrData, memWrMask);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int d0;
        memReady = 1'b1;
        inValid  = 1'b1;
        inData   = {32'h4000_0000, 32'h8000_0000, 32'h0000_0000, 32'h3F80_0000};
        d0 = done_cnt;
        do_start(10'h010, 10'd3);
        wait_done(40, 1'b0);
        inValid = 1'b0;
        step(); step(); step();
        checks++;
        if (writes != 3 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL basic_count: writes=%0d pending=%0d, required 3 0", writes, sb.size());
        end
        checks++;
        if (last_mask !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL basic_mask: mask=%b, required 1001", last_mask);
        end
        checks++;
        if (last_wr_cyc - first_wr_cyc != 2) begin
            errors++;
            $display("[TB] FAIL basic_throughput: span=%0d cycles, required 2", last_wr_cyc - first_wr_cyc);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("[TB] FAIL basic_done_once: pulses=%0d, required 1", done_cnt - d0);
        end
        checks++;
        if (rowCount !== 10'd3) begin
            errors++;
            $display("[TB] FAIL basic_rowcount: rowCount=%0d, required 3", rowCount);
        end
    endtask

    task automatic test_backpressure();
        memReady = 1'b0;
        inValid  = 1'b1;
        inData   = rand_vec();
        do_start(10'h040, 10'd6);
        for (int i = 0; i < 8; i++) begin
            step();
            inData = rand_vec();
        end
        checks++;
        if (acc_idx < FD || acc_idx > FD + 1) begin
            errors++;
            $display("[TB] FAIL bp_accepts: accepted=%0d, required %0d..%0d", acc_idx, FD, FD + 1);
        end
        checks++;
        if (inReady !== 1'b0 || memWrEn !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_stall: inReady=%b memWrEn=%b, required 0 1", inReady, memWrEn);
        end
        memReady = 1'b1;
        wait_done(60, 1'b1);
        inValid = 1'b0;
        step();
        checks++;
        if (writes != 6 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL bp_count: writes=%0d pending=%0d, required 6 0", writes, sb.size());
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] want[4];
        want[0] = 10'h3FE; want[1] = 10'h3FF; want[2] = 10'h000; want[3] = 10'h001;
        memReady = 1'b1;
        inValid  = 1'b1;
        inData   = rand_vec();
        do_start(10'h3FE, 10'd4);
        wait_done(40, 1'b1);
        inValid = 1'b0;
        step();
        checks++;
        if (addr_log.size() != 4) begin
            errors++;
            $display("[TB] FAIL wrap_count: writes=%0d, required 4", addr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (addr_log[i] !== want[i]) begin
                    errors++;
                    $display("[TB] FAIL wrap_addr: write %0d addr=%h, required %h", i, addr_log[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_zero_rows();
        memReady = 1'b1;
        inValid  = 1'b1;
        inData   = rand_vec();
        do_start(10'h080, 10'd0);
        checks++;
        if (done !== 1'b1 || inReady !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_done: done=%b inReady=%b busy=%b, required 1 0 0", done, inReady, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || inReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_after: done=%b inReady=%b, required 0 0", done, inReady);
        end
        step(); step();
        inValid = 1'b0;
        checks++;
        if (writes != 0 || acc_idx != 0) begin
            errors++;
            $display("[TB] FAIL zero_writes: writes=%0d accepts=%0d, required 0 0", writes, acc_idx);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int d0;
        memReady = 1'b1;
        inValid  = 1'b1;
        inData   = rand_vec();
        d0 = done_cnt;
        do_start(10'h0C0, 10'd5);
        n = 0;
        while (writes < 2 && n < 40) begin
            step();
            inData = rand_vec();
            n++;
        end
        checks++;
        if (writes != 2) begin
            errors++;
            $display("[TB] FAIL rmid_progress: writes=%0d, required 2 before reset", writes);
        end
        rst = 1'b1;
        memReady = 1'b0;
        step();
        checks++;
        if ({inReady, memWrEn, busy, done} !== 4'b0000 || memAddr !== '0 || rowCount !== '0 ||
            memWrData !== '0 || memWrMask !== '0) begin
            errors++;
            $display("[TB] FAIL rmid_outputs: ready/en/busy/done=%b addr=%h rowCount=%h, required 0",
                     {inReady, memWrEn, busy, done}, memAddr, rowCount);
        end
        rst = 1'b0;
        step(); step(); step();
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("[TB] FAIL rmid_no_done: pulses=%0d, required 0", done_cnt - d0);
        end
        memReady = 1'b1;
        do_start(10'h0D0, 10'd2);
        wait_done(40, 1'b1);
        inValid = 1'b0;
        step();
        checks++;
        if (writes != 2 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL rmid_restart: writes=%0d pending=%0d, required 2 0", writes, sb.size());
        end
    endtask

    task automatic test_start_busy();
        memReady = 1'b0;
        inValid  = 1'b1;
        inData   = rand_vec();
        do_start(10'h100, 10'd4);
        step(); step();
        start    = 1'b1;
        baseAddr = 10'h200;
        numRows  = 10'd7;
        step();
        start    = 1'b0;
        memReady = 1'b1;
        wait_done(60, 1'b1);
        inValid = 1'b0;
        step();
        checks++;
        if (writes != 4 || sb.size() != 0 || acc_idx != 4) begin
            errors++;
            $display("[TB] FAIL busy_start: writes=%0d accepts=%0d pending=%0d, required 4 4 0",
                     writes, acc_idx, sb.size());
        end
        checks++;
        if (rowCount !== 10'd4) begin
            errors++;
            $display("[TB] FAIL busy_rowcount: rowCount=%0d, required 4", rowCount);
        end
    endtask

    initial begin
        cyc = 0; done_cnt = 0; writes = 0; acc_idx = 0; exp_base = '0;
        first_wr_cyc = 0; last_wr_cyc = 0; last_mask = '0;
        prev_stall = 1'b0; prev_addr = '0; prev_data = '0; prev_mask = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_rows();
        test_reset_mid();
        test_start_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/act_writeback.md
Name: act_writeback

Overview:
- Downstream stage of the ReLU array. Takes each post-activation vector of pactivation lanes and writes it, with a per-lane ReLU-derivative mask, into the activation buffer at consecutive addresses.
- The backward pass reads the mask as dReLU.
- Decouples the ReLU datapath from buffer-port backpressure through a small internal FIFO.
- Runs one layer pass per start command: IDLE → RUN → DONE.

Parameters:
dataWidth, 32, bits per lane (IEEE-754 single)
pactivation, 128, lanes per vector
addrWidth, 10, activation-buffer address width
fifoDepth, 4, internal FIFO entries (power of two, ≥2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle command pulse; sampled only in IDLE
baseAddr  input  addrWidth  first write address; sampled with start
numRows  input  addrWidth  vectors in this pass; sampled with start
inValid  input  1  inData valid
inReady  output  1  block accepts inData this cycle
inData  input  dataWidth*pactivation  ReLU output vector, lane i at [dataWidth*(i+1)-1 : dataWidth*i]
memWrEn  output  1  write request valid
memReady  input  1  buffer port accepts the write
memAddr  output  addrWidth  write address
memWrData  output  dataWidth*pactivation  vector to write
memWrMask  output  pactivation  bit i = dReLU of lane i
rowCount  output  addrWidth  vectors written in the current pass
busy  output  1  high in RUN
done  output  1  one-cycle pulse when the pass completes

Behaviour:
Clock and reset:
- One clock, clk. rst is synchronous and active-high.
- On rst: state=IDLE, FIFO empty, counters 0.
- Reset values of all outputs are 0: inReady, memWrEn, memAddr, memWrData, memWrMask, rowCount, busy, done.
- rst mid-pass abandons the pass: no done pulse, any pending write is dropped.

State machine:
- IDLE: on start, latch baseAddr and numRows, clear acceptCnt, rowCount and FIFO, then go to RUN.
- Special case: start with numRows=0 goes directly to DONE.
- RUN: busy=1. When rowCount reaches the latched numRows, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.

Input side:
- inReady = (state==RUN) && !fifoFull && (acceptCnt < numRows).
- A transfer occurs when inValid && inReady. Push {inData, mask} into the FIFO and increment acceptCnt.
- Vectors offered after numRows have been accepted are not taken (inReady=0).

Mask rule, per lane:
- mask = (sign bit == 0) && (bits [dataWidth-2:0] != 0).
- +0, -0 and negatives give 0.

Output side:
- Registered output stage. memWrEn, memAddr, memWrData and memWrMask hold stable while memWrEn && !memReady.
- A write completes on memWrEn && memReady. rowCount then increments.
- The next FIFO entry may be presented in the same cycle as a completing write, giving one write per cycle at full throughput.
- memAddr = baseAddr + rowCount, modulo 2^addrWidth (wraps silently).

Latency and throughput:
- A vector accepted in cycle N can appear on memWrEn at cycle N+1 at the earliest.
- Sustained rate is 1 vector/cycle with inValid=1 and memReady=1.

FIFO boundaries:
- Push and pop in the same cycle while full: allowed. inReady is computed from full-before-pop and is therefore conservative.
- Same-cycle push and pop while empty: the entry passes through the FIFO; no bypass.

Completion:
- done fires in the cycle after the final write completes, then state returns to IDLE.

Decomposition:
Shared package (act_pkg), holding:
- state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
- the reluMask lane function;
- a lane-slice helper macro/function;
- dataWidth and pactivation defaults.

Sub-module act_wb_fifo:
- synchronous FIFO, width dataWidth*pactivation+pactivation, depth fifoDepth;
- ports: push, pop, full, empty, dout.

act_writeback owns the FSM, the counters and the output register.

Test Plan:
(Bench parameters: pactivation=4, dataWidth=32, fifoDepth=4.)
- Basic pass: start with baseAddr=0x010, numRows=3, inValid=1 and memReady=1 continuously, lanes {0x3F800000, 0x00000000, 0x80000000, 0x40000000} → writes at 0x010, 0x011, 0x012 on consecutive cycles with memWrMask=4'b1001; done pulses once; rowCount=3.
- Backpressure: numRows=6, memReady=0 for 8 cycles → FIFO fills, inReady drops after 4 accepts and memWrEn holds data and address stable; after release, all 6 writes are in order with no loss or duplication.
- Address wrap: addrWidth=10, baseAddr=0x3FE, numRows=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001.
- numRows=0 → done one cycle after start; memWrEn never asserted; inReady stays 0.
- Reset mid-pass: assert rst after 2 of 5 writes → all outputs 0 next cycle and no done pulse; a subsequent start with numRows=2 completes normally.
- Start while busy: a second start pulse during RUN with a different baseAddr is ignored; the first pass's addresses and numRows are unchanged.
